// File: rtl/lcd_row_streamer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_row_streamer
// Description : Streams two 16-character text rows to the character-LCD byte
//               path as a DDRAM-address command followed by 16 characters per
//               line. A frame is sent only when row content changes, after
//               reset or abort, or on an optional periodic refresh.
//               Optional feature macro: LCD_ROW_REFRESH_EN (periodic refresh).
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_row_streamer #(
    parameter int REFRESH_CYCLES = 5_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] row1,
    input  logic [127:0] row2,
    input  logic         init_done,
    output logic         byte_valid,
    output logic [7:0]   byte_data,
    output logic         byte_rs,
    input  logic         byte_ready,
    output logic         busy,
    output logic         frame_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD1 = 3'd1,
        S_ROW1 = 3'd2,
        S_CMD2 = 3'd3,
        S_ROW2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [7:0] c_cmd_line1 = 8'h80;
    localparam logic [7:0] c_cmd_line2 = 8'hC0;
    localparam logic [3:0] c_last_col  = 4'd15;

    state_t       r_state, w_state;
    logic [127:0] r_shadow1, w_shadow1;
    logic [127:0] r_shadow2, w_shadow2;
    logic [3:0]   r_col, w_col;
    logic         r_dirty, w_dirty;
    logic         r_valid, w_valid;
    logic [7:0]   r_data, w_data;
    logic         r_rs, w_rs;
    logic         r_busy, r_done;
    logic         w_xfer;
    logic         w_start;
    logic         w_refresh_wrap;

    // Pick column col of a packed row (column 0 in the top byte) and replace
    // anything outside printable ASCII with a space.
    function automatic logic [7:0] f_char(input logic [127:0] row, input logic [3:0] col);
        logic [7:0] b;
        b = row[{~col, 3'b000} +: 8];
        return ((b < 8'h20) || (b > 8'h7E)) ? 8'h20 : b;
    endfunction

    assign w_xfer  = r_valid & byte_ready;
    assign w_start = init_done & (r_dirty | ({row1, row2} != {r_shadow1, r_shadow2}));

`ifdef LCD_ROW_REFRESH_EN
    localparam int c_cnt_w = $clog2(REFRESH_CYCLES);
    localparam logic [c_cnt_w-1:0] c_refresh_last = c_cnt_w'(REFRESH_CYCLES - 1);

    logic [c_cnt_w-1:0] r_refresh_cnt;

    assign w_refresh_wrap = (r_refresh_cnt == c_refresh_last);

    // Free-running refresh timer; each wrap marks the display stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh_cnt <= '0;
        end else if (w_refresh_wrap) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end
`else
    // No periodic refresh; the legal period is never zero so this stays low.
    assign w_refresh_wrap = (REFRESH_CYCLES == 0);
`endif

    // Next-state and next-output logic; the offered byte only advances on a transfer.
    always_comb begin
        w_state   = r_state;
        w_shadow1 = r_shadow1;
        w_shadow2 = r_shadow2;
        w_col     = r_col;
        w_dirty   = r_dirty;
        w_valid   = r_valid;
        w_data    = r_data;
        w_rs      = r_rs;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_shadow1 = row1;
                    w_shadow2 = row2;
                    w_dirty   = 1'b0;
                    w_col     = 4'd0;
                    w_state   = S_CMD1;
                    w_valid   = 1'b1;
                    w_data    = c_cmd_line1;
                    w_rs      = 1'b0;
                end
            end
            S_CMD1: begin
                if (w_xfer) begin
                    w_state = S_ROW1;
                    w_col   = 4'd0;
                    w_data  = f_char(r_shadow1, 4'd0);
                    w_rs    = 1'b1;
                end
            end
            S_ROW1: begin
                if (w_xfer) begin
                    if (r_col == c_last_col) begin
                        w_state = S_CMD2;
                        w_col   = 4'd0;
                        w_data  = c_cmd_line2;
                        w_rs    = 1'b0;
                    end else begin
                        w_col  = r_col + 4'd1;
                        w_data = f_char(r_shadow1, r_col + 4'd1);
                    end
                end
            end
            S_CMD2: begin
                if (w_xfer) begin
                    w_state = S_ROW2;
                    w_col   = 4'd0;
                    w_data  = f_char(r_shadow2, 4'd0);
                    w_rs    = 1'b1;
                end
            end
            S_ROW2: begin
                if (w_xfer) begin
                    if (r_col == c_last_col) begin
                        w_state = S_DONE;
                        w_col   = 4'd0;
                        w_valid = 1'b0;
                    end else begin
                        w_col  = r_col + 4'd1;
                        w_data = f_char(r_shadow2, r_col + 4'd1);
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_valid = 1'b0;
            end
        endcase

        // Losing the LCD mid-frame abandons the frame and forces a resend.
        if ((r_state != S_IDLE) && !init_done) begin
            w_state = S_IDLE;
            w_valid = 1'b0;
            w_dirty = 1'b1;
        end

        if (w_refresh_wrap) begin
            w_dirty = 1'b1;
        end
    end

    // State, shadow rows and registered byte-path outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_shadow1 <= '0;
            r_shadow2 <= '0;
            r_col     <= 4'd0;
            r_dirty   <= 1'b1;
            r_valid   <= 1'b0;
            r_data    <= 8'h00;
            r_rs      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_shadow1 <= w_shadow1;
            r_shadow2 <= w_shadow2;
            r_col     <= w_col;
            r_dirty   <= w_dirty;
            r_valid   <= w_valid;
            r_data    <= w_data;
            r_rs      <= w_rs;
            r_busy    <= (w_state != S_IDLE);
            r_done    <= (w_state == S_DONE);
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_data;
    assign byte_rs    = r_rs;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_row_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_row_streamer
// Description : Self-checking bench for lcd_row_streamer. Expected byte
//               streams are built from the row text with a simple frame
//               model and compared against the transfers observed on the
//               byte path. Build with LCD_ROW_REFRESH_EN to exercise refresh.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_row_streamer;

    logic         clk;
    logic         rst;
    logic [127:0] row1;
    logic [127:0] row2;
    logic         init_done;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_rs;
    logic         byte_ready;
    logic         busy;
    logic         frame_done;

    int n_total = 0;
    int n_pass  = 0;
    int n_done  = 0;
    int n_vcyc  = 0;

    logic [8:0] xq[$];
    logic [8:0] eq[$];

    logic       r_prev_stall = 1'b0;
    logic [8:0] r_prev_byte  = 9'h0;

    lcd_row_streamer #(.REFRESH_CYCLES(200)) dut (
        .clk        (clk),
        .rst        (rst),
        .row1       (row1),
        .row2       (row2),
        .init_done  (init_done),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_rs    (byte_rs),
        .byte_ready (byte_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Transfer monitor: records accepted bytes and checks stall stability.
    always @(posedge clk) begin
        if (rst) begin
            if (r_prev_stall)
                check("hold_stable", {23'd0, byte_valid, byte_rs, byte_data}, {23'd0, 1'b1, r_prev_byte});
            if (byte_valid && byte_ready) xq.push_back({byte_rs, byte_data});
            if (frame_done) n_done++;
            if (byte_valid) n_vcyc++;
            r_prev_stall <= byte_valid && !byte_ready && init_done;
            r_prev_byte  <= {byte_rs, byte_data};
        end
    end

    // Reference: address command then 16 printable-or-space characters per line.
    function automatic logic [7:0] model_char(input logic [127:0] row, input int c);
        logic [7:0] b;
        b = row[127 - 8*c -: 8];
        if (b < 8'h20 || b > 8'h7E) b = 8'h20;
        return b;
    endfunction

    task automatic expect_frame(input logic [127:0] a, input logic [127:0] b);
        eq.push_back({1'b0, 8'h80});
        for (int c = 0; c < 16; c++) eq.push_back({1'b1, model_char(a, c)});
        eq.push_back({1'b0, 8'hC0});
        for (int c = 0; c < 16; c++) eq.push_back({1'b1, model_char(b, c)});
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, xq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < xq.size(); i++)
            check(tag, {23'd0, xq[i]}, {23'd0, eq[i]});
        xq.delete();
        eq.delete();
    endtask

    task automatic wait_done(input int target, input int budget, input bit rand_ready, input string tag);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            if (rand_ready) byte_ready = ($urandom_range(0, 2) == 0);
            k++;
        end
        byte_ready = 1'b1;
        check(tag, n_done, target);
    endtask

    task automatic wait_xfers(input int n, input int budget, input string tag);
        int k = 0;
        while (xq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, xq.size(), n);
    endtask

    function automatic logic [127:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] a1, a2, b2;
        int d0, v0;

        // Reset values
        rst = 1'b0; init_done = 1'b0; byte_ready = 1'b0; row1 = '0; row2 = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", byte_valid, 1'b0);
        check("rst_data", byte_data, 8'h00);
        check("rst_rs", byte_rs, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_init", busy, 1'b0);

        // First frame with known text; start latency and valid duration
        row1 = "Temp: 25'C      ";
        row2 = "Humi: 60%       ";
        byte_ready = 1'b1;
        d0 = n_done; v0 = n_vcyc;
        init_done = 1'b1;
        @(negedge clk);
        check("start_busy", busy, 1'b1);
        check("start_valid", byte_valid, 1'b1);
        check("start_data", byte_data, 8'h80);
        check("start_rs", byte_rs, 1'b0);
        wait_done(d0 + 1, 100, 1'b0, "text_done");
        check("text_vcyc", n_vcyc - v0, 34);
        repeat (30) @(negedge clk);
        check("text_single_done", n_done, d0 + 1);
        expect_frame("Temp: 25'C      ", "Humi: 60%       ");
        compare_stream("text_stream");

        // Zero-filled line 1 is sent as spaces
        d0 = n_done; v0 = n_vcyc;
        row1 = '0;
        wait_done(d0 + 1, 100, 1'b0, "zero_done");
        check("zero_vcyc", n_vcyc - v0, 34);
        expect_frame('0, row2);
        compare_stream("zero_stream");

        // Random rows (including unprintable bytes) under random stalls
        d0 = n_done;
        a1 = rand_row(); a2 = rand_row();
        row1 = a1; row2 = a2;
        wait_done(d0 + 1, 1000, 1'b1, "stall_done");
        repeat (5) @(negedge clk);
        expect_frame(a1, a2);
        compare_stream("stall_stream");

        // Row 2 change mid-frame: old snapshot, then exactly one new frame
        d0 = n_done;
        a1 = rand_row(); a2 = rand_row(); b2 = rand_row();
        row1 = a1; row2 = a2;
        wait_xfers(10, 100, "mid_reach10");
        row2 = b2;
        wait_done(d0 + 2, 200, 1'b0, "mid_done");
        repeat (30) @(negedge clk);
        check("mid_two_frames", n_done, d0 + 2);
        expect_frame(a1, a2);
        expect_frame(a1, b2);
        compare_stream("mid_stream");

        // Abort at transfer 20, then a full restart
        d0 = n_done;
        a1 = rand_row();
        row1 = a1;
        wait_xfers(20, 100, "abort_reach20");
        init_done = 1'b0;
        byte_ready = 1'b0;
        @(negedge clk);
        check("abort_valid", byte_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        repeat (10) @(negedge clk);
        check("abort_no_done", n_done, d0);
        expect_frame(a1, row2);
        while (eq.size() > 20) void'(eq.pop_back());
        compare_stream("abort_prefix");
        byte_ready = 1'b1;
        init_done = 1'b1;
        wait_done(d0 + 1, 100, 1'b0, "restart_done");
        expect_frame(a1, row2);
        compare_stream("restart_stream");

        // Static rows: periodic frames only with refresh enabled
        d0 = n_done;
        repeat (450) @(negedge clk);
`ifdef LCD_ROW_REFRESH_EN
        check("refresh_frames", (n_done - d0 >= 2) && (n_done - d0 <= 3), 1'b1);
`else
        check("static_no_frame", n_done, d0);
        check("static_no_bytes", xq.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
